seq11_tx: RTL and testbench
===========================

# seq11_tx

Serial bit-stream transmitter for the "11" sequence detector's `w` input. It accepts a parallel word over a load/ready handshake and shifts it out MSB-first, one bit per clock, on `w`. Alongside each bit it drives `exp_z`, the detector output a correct "11" detector must produce for that bit, and it keeps a saturating count of "11" pairs. The bench uses it as the stimulus and scoreboard source for detector verification.

## Interface
- `WIDTH`, 8: bits per word; must be 2 or more.
- `CNT_W`, 8: width of the pair counter.

- `Clock`  in  1  clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high; forces every register to its reset value immediately.
- `load`  in  1  request to start a word; accepted only when `load & ready` at a rising edge.
- `data`  in  WIDTH  word to transmit; sampled only on an accepted load.
- `clr`  in  1  synchronous clear of `pair_cnt`.
- `ready`  out  1  can accept a word. Equals `!active | last`.
- `w`  out  1  serial bit, registered.
- `active`  out  1  `w` currently carries a data bit.
- `last`  out  1  `w` currently carries bit 0 of the word.
- `exp_z`  out  1  expected detector output for the current bit, registered.
- `pair_cnt`  out  CNT_W  number of asserted `exp_z` bits since reset or `clr`; saturates at all-ones.

## Operation
- Two states:
  - **IDLE**: `active`=0, `w`=0.
  - **SHIFT**: `active`=1.
- A down-counter `idx` (width clog2(WIDTH)) selects the current bit of the captured shift register.
- **IDLE → SHIFT** on an accepted load:
  - capture `data`;
  - `w` ← `data[WIDTH-1]`;
  - `idx` ← WIDTH-1.
- **SHIFT, `idx`>0**:
  - `w` ← next lower bit; `idx` decrements.
  - `load` is ignored because `ready`=0.
- **SHIFT, `idx`=0**:
  - `last`=1 and `ready`=1.
  - An accepted load starts the new word on the next edge, with no gap. State stays SHIFT and `active` stays 1.
  - Otherwise the block goes to IDLE: `w`=0, `last`=0.
- **History bit `prev`**:
  - Equals the `w` value of the previous cycle.
  - It is 0 whenever the previous cycle was IDLE. This is consistent with the line idling at 0, which returns the detector to state A.
- **Expected output:** every edge that registers a new `w` also registers `exp_z` ← `w_next & w_current`. In IDLE, `exp_z`=0.
- **Pair counter:** `pair_cnt` increments on the same edge that sets `exp_z`=1, so the updated count is visible in the same cycle as that `exp_z`.
  - Saturates at 2^CNT_W−1 with no wrap.
  - `clr` takes precedence: `clr` together with an increment gives 0.
- **Reset mid-word:** the word is aborted and no partial state is retained. The next load starts from IDLE semantics, with `prev`=0.
- **Reset values:** state IDLE, `w`=0, `active`=0, `last`=0, `exp_z`=0, `pair_cnt`=0, `idx`=0, shift register 0. Hence `ready`=1.

## Timing
- Load accepted at edge E0:
  - `w`=`data[WIDTH-1]` during the cycle after E0.
  - `w`=`data[0]` during the cycle after E0+WIDTH−1, with `last`=1.
- Latency from load to first bit: 1 cycle. One bit per cycle.
- Throughput: one word per WIDTH cycles with back-to-back loads.
- Without a new load, E0+WIDTH returns the block to IDLE: `active`=0, `w`=0.
- `exp_z` and `pair_cnt` are aligned with `w`; both change on the same edge.
- `ready` is combinational from registered `active`/`last` only; there is no path from `load` or `data`.

## Test plan
1. **Reset:** assert `Reset` mid-clock.
   - Response: immediately `w`=0, `active`=0, `last`=0, `exp_z`=0, `pair_cnt`=0, `ready`=1.
2. **Single word from IDLE:** load 8'b0110_1110 (WIDTH=8).
   - `w` = 0,1,1,0,1,1,1,0.
   - `exp_z` = 0,0,1,0,0,1,1,0.
   - `last` on the 8th bit; `pair_cnt`=3; then IDLE.
3. **Back-to-back:** load 8'h01, then load 8'h80 during `last`.
   - No gap; `active` stays 1.
   - `exp_z`=1 on the first bit of the second word; `pair_cnt`=1.
4. **Idle gap:** load 8'h01, one idle cycle, then load 8'h80.
   - `exp_z`=0 throughout; `pair_cnt`=0.
   - A `load` pulsed mid-word with `ready`=0 is ignored: the bit sequence is unchanged.
5. **Saturation and clear:** CNT_W=2, load 8'hFF.
   - `exp_z` is 1 on bits 2–8; `pair_cnt` goes 1,2,3,3,3,3,3.
   - `clr` asserted on an incrementing edge gives `pair_cnt`=0.
6. **Reset mid-word:** assert `Reset` after 3 bits of 8'hFF, release, then load 8'hC0.
   - First bit has `exp_z`=0, second bit has `exp_z`=1; `pair_cnt` ends at 1.

Source files
------------

// File: rtl/seq11_tx.sv
// seq11_tx: serial transmitter for the "11" detector's w input.
// Shifts a parallel word out MSB-first and drives, alongside each bit, the
// output a correct "11" detector must produce, plus a saturating pair count.
module seq11_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             clr,
  output logic             ready,
  output logic             w,
  output logic             active,
  output logic             last,
  output logic             exp_z,
  output logic [CNT_W-1:0] pair_cnt
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [IW-1:0]    idx, idx_n;
  logic             w_n;
  logic             exp_z_n;
  logic [CNT_W-1:0] cnt_n;

  // Pair counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // active/last/ready depend only on registered state, never on load/data.
  assign active = (state == SHIFT);
  assign last   = active && (idx == '0);
  assign ready  = !active || last;

  // Next-state, next bit, and expected detector output. The registered w is
  // the history bit: it is already 0 whenever the previous cycle was idle.
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    idx_n   = idx;
    w_n     = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          state_n = SHIFT;
          sreg_n  = data;
          w_n     = data[WIDTH-1];
          idx_n   = IW'(WIDTH-1);
        end
      end
      SHIFT: begin
        if (idx != '0) begin
          w_n   = sreg[idx - IW'(1)];
          idx_n = idx - IW'(1);
        end else if (load) begin
          // Back-to-back word: start the next one with no idle gap.
          sreg_n = data;
          w_n    = data[WIDTH-1];
          idx_n  = IW'(WIDTH-1);
        end else begin
          state_n = IDLE;
          idx_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    exp_z_n = w_n & w;
    if (clr)
      cnt_n = '0;
    else if (exp_z_n)
      cnt_n = sat_inc(pair_cnt);
    else
      cnt_n = pair_cnt;
  end

  // State register; an asynchronous reset aborts any word in flight.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      sreg     <= '0;
      idx      <= '0;
      w        <= 1'b0;
      exp_z    <= 1'b0;
      pair_cnt <= '0;
    end else begin
      state    <= state_n;
      sreg     <= sreg_n;
      idx      <= idx_n;
      w        <= w_n;
      exp_z    <= exp_z_n;
      pair_cnt <= cnt_n;
    end
  end

endmodule

// File: tb/tb_seq11_tx.sv
// tb_seq11_tx: directed bench for seq11_tx with hand-computed expectations.
// A second instance with CNT_W=2 shares the inputs for the saturation case.
module tb_seq11_tx;

  logic       Clock;
  logic       Reset;
  logic       load;
  logic [7:0] data;
  logic       clr;
  logic       ready, w, active, last, exp_z;
  logic [7:0] pair_cnt;
  logic       ready2, w2, active2, last2, exp_z2;
  logic [1:0] pair_cnt2;

  int n_checks = 0;
  int n_fails  = 0;

  seq11_tx #(.WIDTH(8), .CNT_W(8)) dut (
    .Clock(Clock), .Reset(Reset), .load(load), .data(data), .clr(clr),
    .ready(ready), .w(w), .active(active), .last(last), .exp_z(exp_z),
    .pair_cnt(pair_cnt)
  );

  seq11_tx #(.WIDTH(8), .CNT_W(2)) dut2 (
    .Clock(Clock), .Reset(Reset), .load(load), .data(data), .clr(clr),
    .ready(ready2), .w(w2), .active(active2), .last(last2), .exp_z(exp_z2),
    .pair_cnt(pair_cnt2)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".w"},      32'(w), 0);
    chk({tag, ".active"}, 32'(active), 0);
    chk({tag, ".last"},   32'(last), 0);
    chk({tag, ".exp_z"},  32'(exp_z), 0);
    chk({tag, ".ready"},  32'(ready), 1);
  endtask

  logic [7:0] ew, ez;
  int         ecnt [8];

  initial begin
    Reset = 1'b0;
    load  = 1'b0;
    data  = 8'h00;
    clr   = 1'b0;

    // 1. reset asserted mid-clock takes effect immediately
    @(posedge Clock);
    #3 Reset = 1'b1;
    #1;
    chk_idle("rst");
    chk("rst.cnt", 32'(pair_cnt), 0);
    chk("rst.cnt2", 32'(pair_cnt2), 0);
    #2 Reset = 1'b0;
    tick();
    chk_idle("post_rst");

    // 2. single word 0110_1110 from idle
    ew = 8'b0110_1110;
    ez = 8'b0010_0110;
    ecnt = '{0, 0, 1, 1, 1, 2, 3, 3};
    load = 1'b1; data = 8'b0110_1110;
    tick();
    load = 1'b0; data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2.w[%0d]", i),      32'(w), 32'(ew[7-i]));
      chk($sformatf("t2.exp_z[%0d]", i),  32'(exp_z), 32'(ez[7-i]));
      chk($sformatf("t2.last[%0d]", i),   32'(last), (i == 7) ? 1 : 0);
      chk($sformatf("t2.ready[%0d]", i),  32'(ready), (i == 7) ? 1 : 0);
      chk($sformatf("t2.active[%0d]", i), 32'(active), 1);
      chk($sformatf("t2.cnt[%0d]", i),    32'(pair_cnt), ecnt[i]);
      tick();
    end
    chk_idle("t2.end");
    chk("t2.cnt_end", 32'(pair_cnt), 3);

    // 3. back-to-back 8'h01 then 8'h80 loaded during last
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t3.clr", 32'(pair_cnt), 0);
    load = 1'b1; data = 8'h01;
    tick();
    load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("t3.a.w[%0d]", i), 32'(w), 0);
      tick();
    end
    chk("t3.a.w7", 32'(w), 1);
    chk("t3.a.last", 32'(last), 1);
    chk("t3.a.ready", 32'(ready), 1);
    load = 1'b1; data = 8'h80;
    tick();
    load = 1'b0; data = 8'h00;
    chk("t3.b.active", 32'(active), 1);
    chk("t3.b.w0", 32'(w), 1);
    chk("t3.b.exp_z0", 32'(exp_z), 1);
    chk("t3.b.cnt0", 32'(pair_cnt), 1);
    chk("t3.b.last0", 32'(last), 0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("t3.b.w[%0d]", i), 32'(w), 0);
      chk($sformatf("t3.b.exp_z[%0d]", i), 32'(exp_z), 0);
    end
    chk("t3.b.last7", 32'(last), 1);
    tick();
    chk_idle("t3.end");
    chk("t3.cnt_end", 32'(pair_cnt), 1);

    // 4. idle gap between 8'h01 and 8'h80; mid-word load ignored
    clr = 1'b1; tick(); clr = 1'b0;
    load = 1'b1; data = 8'h01;
    tick();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4.a.w[%0d]", i), 32'(w), (i == 7) ? 1 : 0);
      chk($sformatf("t4.a.exp_z[%0d]", i), 32'(exp_z), 0);
      if (i == 2) begin
        load = 1'b1; data = 8'hFF;
      end else begin
        load = 1'b0; data = 8'h00;
      end
      tick();
    end
    chk_idle("t4.gap");
    load = 1'b1; data = 8'h80;
    tick();
    load = 1'b0; data = 8'h00;
    chk("t4.b.w0", 32'(w), 1);
    chk("t4.b.exp_z0", 32'(exp_z), 0);
    for (int i = 1; i < 8; i++) tick();
    chk("t4.b.last7", 32'(last), 1);
    chk("t4.b.w7", 32'(w), 0);
    tick();
    chk_idle("t4.end");
    chk("t4.cnt_end", 32'(pair_cnt), 0);

    // 5. saturation on the 2-bit counter, then clear on an incrementing edge
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t5.clr2", 32'(pair_cnt2), 0);
    ecnt = '{0, 1, 2, 3, 3, 3, 3, 3};
    load = 1'b1; data = 8'hFF;
    tick();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t5.w[%0d]", i), 32'(w2), 1);
      chk($sformatf("t5.exp_z[%0d]", i), 32'(exp_z2), (i == 0) ? 0 : 1);
      chk($sformatf("t5.cnt2[%0d]", i), 32'(pair_cnt2), ecnt[i]);
      if (i < 7) tick();
    end
    load = 1'b1; data = 8'hFF; clr = 1'b1;
    tick();
    load = 1'b0; clr = 1'b0;
    chk("t5.clr.exp_z", 32'(exp_z2), 1);
    chk("t5.clr.cnt2", 32'(pair_cnt2), 0);
    chk("t5.clr.cnt", 32'(pair_cnt), 0);
    tick();
    chk("t5.after_clr.cnt2", 32'(pair_cnt2), 1);
    for (int i = 2; i < 8; i++) tick();
    chk("t5.sat.cnt2", 32'(pair_cnt2), 3);
    tick();
    chk_idle("t5.end");

    // 6. reset after three bits of 8'hFF, then 8'hC0
    clr = 1'b1; tick(); clr = 1'b0;
    load = 1'b1; data = 8'hFF;
    tick();
    load = 1'b0;
    tick();
    tick();
    chk("t6.pre.cnt", 32'(pair_cnt), 2);
    #2 Reset = 1'b1;
    #1;
    chk_idle("t6.rst");
    chk("t6.rst.cnt", 32'(pair_cnt), 0);
    #2 Reset = 1'b0;
    tick();
    chk_idle("t6.idle");
    load = 1'b1; data = 8'hC0;
    tick();
    load = 1'b0; data = 8'h00;
    chk("t6.w0", 32'(w), 1);
    chk("t6.exp_z0", 32'(exp_z), 0);
    chk("t6.cnt0", 32'(pair_cnt), 0);
    tick();
    chk("t6.w1", 32'(w), 1);
    chk("t6.exp_z1", 32'(exp_z), 1);
    chk("t6.cnt1", 32'(pair_cnt), 1);
    tick();
    chk("t6.w2", 32'(w), 0);
    chk("t6.exp_z2", 32'(exp_z), 0);
    for (int i = 3; i < 8; i++) tick();
    chk("t6.last7", 32'(last), 1);
    tick();
    chk_idle("t6.end");
    chk("t6.cnt_end", 32'(pair_cnt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
